regfile_write_arbiter: RTL

//   Shares the single regfile write port (ctrl_writeEn/ctrl_writeReg/data_writeReg) between
//   CPU writeback and NUM_AUX game-side writers (screen-end flag, random-number source,

---
 rtl/regfile_write_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Shares the single regfile write port between CPU writeback and NUM_AUX
// req/ack requesters, with CPU priority, round-robin aux service and starvation relief.
module regfile_write_arbiter #(
    parameter int NUM_AUX      = 3,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clock,
    input  logic                    ctrl_reset,
    input  logic                    cpu_writeEn,
    input  logic [4:0]              cpu_writeReg,
    input  logic [31:0]             cpu_writeData,
    output logic                    cpu_stall,
    input  logic [NUM_AUX-1:0]      aux_req,
    input  logic [5*NUM_AUX-1:0]    aux_writeReg,
    input  logic [32*NUM_AUX-1:0]   aux_writeData,
    output logic [NUM_AUX-1:0]      aux_ack,
    output logic                    ctrl_writeEn,
    output logic [4:0]              ctrl_writeReg,
    output logic [31:0]             data_writeReg
);

    localparam int PW = (NUM_AUX > 1) ? $clog2(NUM_AUX) : 1;
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {NORMAL, FORCE} state_t;

    state_t          state, state_next;
    logic [PW-1:0]   rr_ptr, rr_next;
    logic [CW-1:0]   starve_cnt, cnt_next;
    logic            stall_next;
    logic            wen_next;
    logic [4:0]      reg_next;
    logic [31:0]     data_next;
    logic            grant_valid;
    logic [PW-1:0]   grant_idx;
    logic            do_grant;
    logic [NUM_AUX-1:0] ack_raw;
    logic [4:0]      grant_reg;
    logic [31:0]     grant_data;

    // First pending requester at or above rr_ptr, wrapping around.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_AUX; i++) begin
            if (!grant_valid && aux_req[PW'((int'(rr_ptr) + i) % NUM_AUX)]) begin
                grant_valid = 1'b1;
                grant_idx   = PW'((int'(rr_ptr) + i) % NUM_AUX);
            end
        end
    end

    assign grant_reg  = aux_writeReg[int'(grant_idx)*5 +: 5];
    assign grant_data = aux_writeData[int'(grant_idx)*32 +: 32];

    always_comb begin
        state_next = state;
        cnt_next   = starve_cnt;
        rr_next    = rr_ptr;
        stall_next = 1'b0;
        wen_next   = 1'b0;
        reg_next   = ctrl_writeReg;
        data_next  = data_writeReg;
        do_grant   = 1'b0;
        ack_raw    = '0;

        case (state)
            NORMAL: begin
                if (cpu_writeEn) begin
                    wen_next  = 1'b1;
                    reg_next  = cpu_writeReg;
                    data_next = cpu_writeData;
                    if (|aux_req) begin
                        cnt_next = (starve_cnt >= CW'(STARVE_LIMIT - 1)) ? CW'(STARVE_LIMIT)
                                                                        : starve_cnt + 1'b1;
                        if (cnt_next == CW'(STARVE_LIMIT)) begin
                            state_next = FORCE;
                            stall_next = 1'b1;
                        end
                    end else begin
                        cnt_next = '0;
                    end
                end else begin
                    cnt_next = '0;
                    do_grant = grant_valid;
                end
            end
            FORCE: begin
                // CPU is holding its write; it re-presents it next cycle.
                state_next = NORMAL;
                cnt_next   = '0;
                do_grant   = grant_valid;
            end
            default: state_next = NORMAL;
        endcase

        if (do_grant) begin
            ack_raw[grant_idx] = 1'b1;
            rr_next = (grant_idx == PW'(NUM_AUX - 1)) ? '0 : grant_idx + 1'b1;
            // Writes to r0 are acknowledged but never reach the regfile.
            if (grant_reg != 5'd0) begin
                wen_next  = 1'b1;
                reg_next  = grant_reg;
                data_next = grant_data;
            end
        end
    end

    assign aux_ack = ctrl_reset ? '0 : ack_raw;

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            state         <= NORMAL;
            rr_ptr        <= '0;
            starve_cnt    <= '0;
            cpu_stall     <= 1'b0;
            ctrl_writeEn  <= 1'b0;
            ctrl_writeReg <= '0;
            data_writeReg <= '0;
        end else begin
            state         <= state_next;
            rr_ptr        <= rr_next;
            starve_cnt    <= cnt_next;
            cpu_stall     <= stall_next;
            ctrl_writeEn  <= wen_next;
            ctrl_writeReg <= reg_next;
            data_writeReg <= data_next;
        end
    end

endmodule
